// File: rtl/isram_loader_if.sv
// Word-stream handshake and byte-wide SRAM write/readback bus of the
// instruction SRAM loader.
interface isram_loader_if #(
    parameter int m = 10,
    parameter int n = 8
);
    logic           word_valid;
    logic [4*n-1:0] word;
    logic           word_ready;
    logic           w_en;
    logic [m-1:0]   addr;
    logic [n-1:0]   data;
    logic [4*n-1:0] inst;

    modport master (
        input  word_valid,
        input  word,
        input  inst,
        output word_ready,
        output w_en,
        output addr,
        output data
    );

    modport slave (
        output word_valid,
        output word,
        output inst,
        input  word_ready,
        input  w_en,
        input  addr,
        input  data
    );
endinterface

// File: rtl/isram_loader.sv
// Serialises 32-bit instruction words into big-endian byte writes to the SRAM.
// Define ISRAM_LOADER_READBACK_EN to verify each word after it is written.
module isram_loader #(
    parameter int m = 10,
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [m-1:0]   base_addr_i,
    input  logic [m-2:0]   num_words_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           wrap_o,
    output logic           err_o,
    isram_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        CHECK,
        FINISH
    } state_e;

    state_e         state_q, state_d;
    logic [m-1:0]   ptr_q, ptr_d;
    logic [m-2:0]   left_q, left_d;
    logic [4*n-1:0] buf_q, buf_d;
    logic [1:0]     idx_q, idx_d;
    logic           busy_q, busy_d;
    logic           wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_words_i == '0) ? FINISH : WAIT;
                end
            end
            WAIT: begin
                if (bus.word_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == 2'd3) begin
`ifdef ISRAM_LOADER_READBACK_EN
                    state_d = CHECK;
`else
                    state_d = (left_q != (m-1)'(1)) ? WAIT : FINISH;
`endif
                end
            end
`ifdef ISRAM_LOADER_READBACK_EN
            CHECK: begin
                state_d = (left_q != '0) ? WAIT : FINISH;
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.word_ready = 1'b0;
        bus.w_en       = 1'b0;
        bus.addr       = ptr_q;
        done_o         = 1'b0;
        unique case (state_q)
            WAIT:    bus.word_ready = 1'b1;
            WRITE:   bus.w_en = 1'b1;
            CHECK:   bus.addr = ptr_q - m'(4);
            FINISH:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Big-endian: byte 0 is the most significant byte of the word.
    always_comb begin
        unique case (idx_q)
            2'd0:    bus.data = buf_q[4*n-1:3*n];
            2'd1:    bus.data = buf_q[3*n-1:2*n];
            2'd2:    bus.data = buf_q[2*n-1:n];
            default: bus.data = buf_q[n-1:0];
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        left_d = left_q;
        buf_d  = buf_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        wrap_d = wrap_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    ptr_d  = {base_addr_i[m-1:2], 2'b00};
                    left_d = num_words_i;
                    wrap_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.word_valid) begin
                    buf_d = bus.word;
                    idx_d = 2'd0;
                end
            end
            WRITE: begin
                ptr_d = ptr_q + m'(1);
                idx_d = idx_q + 2'd1;
                if (ptr_q == '1) begin
                    wrap_d = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    left_d = left_q - (m-1)'(1);
                end
            end
            FINISH: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            left_q <= '0;
            buf_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            left_q <= left_d;
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            wrap_q <= wrap_d;
        end
    end

    assign busy_o = busy_q;
    assign wrap_o = wrap_q;

`ifdef ISRAM_LOADER_READBACK_EN
    logic err_q, err_d;

    // A failed readback is only flagged; the load keeps going.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && start_i) begin
            err_d = 1'b0;
        end else if (state_q == CHECK && bus.inst != buf_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_inst;
    assign unused_inst = ^bus.inst;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_isram_loader.sv
// Scoreboard bench for isram_loader: expected byte writes are queued as
// words are offered and popped as the SRAM write port fires.
module tb_isram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] base = '0;
    logic [8:0] num = '0;
    logic       busy, done, wrap, err;

    isram_loader_if #(.m(10), .n(8)) bus ();

    isram_loader #(.m(10), .n(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_addr_i (base),
        .num_words_i (num),
        .busy_o      (busy),
        .done_o      (done),
        .wrap_o      (wrap),
        .err_o       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

`ifdef ISRAM_LOADER_READBACK_EN
    localparam int PER = 6;
`else
    localparam int PER = 5;
`endif

    // SRAM model; optional stuck-at-zero byte at 0x012
    logic [7:0] mem [0:1023];
    logic       stuck = 1'b0;

    always @(posedge clk) begin
        if (bus.w_en) begin
            mem[bus.addr] <= (stuck && bus.addr == 10'h012) ? 8'h00 : bus.data;
        end
    end

    assign bus.inst = {mem[bus.addr], mem[bus.addr + 10'd1],
                       mem[bus.addr + 10'd2], mem[bus.addr + 10'd3]};

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    logic [17:0] sb [$];
    logic [31:0] wq [$];
    logic [17:0] e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.w_en) begin
            if (sb.size() == 0) begin
                chk("unexp_wr", 32'(bus.w_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.addr), 32'(e[17:8]));
                chk("wr_data", 32'(bus.data), 32'(e[7:0]));
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic load(input logic [9:0] b, input int gap, input bit midstart);
        int          nw;
        int          t0;
        bit          got;
        logic [9:0]  p;
        logic [31:0] w;
        nw = wq.size();
        p = b & 10'h3FC;
        n_done = 0;
        base = b;
        num = 9'(nw);
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        bus.word_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.word_ready), 32'd1);
            tick();
        end
        for (int i = 0; i < nw; i++) begin
            w = wq[i];
            bus.word = w;
            bus.word_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                if (bus.word_ready) got = 1'b1;
            end
            if (!got) chk("ready_to", 32'(bus.word_ready), 32'd1);
            for (int j = 0; j < 4; j++) begin
                sb.push_back({p, w[31-8*j -: 8]});
                p = p + 10'd1;
            end
            tick();
            if (midstart && i == 0) begin
                base = 10'h200;
                num = 9'd5;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        bus.word_valid = 1'b0;
        for (int k = 0; k < 200 && n_done == 0; k++) @(posedge clk);
        tick();
        tick();
        chk("done_cnt", n_done, 1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), 32'd0);
        chk("sb_empty", sb.size(), 0);
        if (n_done != 0) chk("latency", done_cyc - t0 + 1, 1 + PER * nw + gap);
    endtask

    initial begin
        bus.word_valid = 1'b0;
        bus.word = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wen", 32'(bus.w_en), 32'd0);
        chk("rst_rdy", 32'(bus.word_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        tick();
        rst = 1'b0;

        bus.word_valid = 1'b1;
        bus.word = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_wen", 32'(bus.w_en), 32'd0);
            chk("idle_rdy", 32'(bus.word_ready), 32'd0);
            tick();
        end
        bus.word_valid = 1'b0;

        wq = '{32'hDEADBEEF, 32'h00100093};
        load(10'h010, 0, 1'b0);
        chk("mem_010", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
        chk("mem_014", {mem[20], mem[21], mem[22], mem[23]}, 32'h00100093);
        chk("wrap_norm", 32'(wrap), 32'd0);
        chk("err_norm", 32'(err), 32'd0);

        wq = '{32'hCAFEF00D};
        load(10'h013, 3, 1'b1);
        chk("mem_bp", {mem[16], mem[17], mem[18], mem[19]}, 32'hCAFEF00D);
        tick();
        chk("busy_ign", 32'(busy), 32'd0);

        wq.delete();
        load(10'h100, 0, 1'b0);

        wq = '{32'h11223344, 32'h55667788};
        load(10'h3FC, 0, 1'b0);
        chk("wrap_set", 32'(wrap), 32'd1);
        chk("mem_000", {mem[0], mem[1], mem[2], mem[3]}, 32'h55667788);

        wq = '{32'hA5A5A5A5};
        load(10'h020, 0, 1'b0);
        chk("wrap_clr", 32'(wrap), 32'd0);

        n_done = 0;
        base = 10'h040;
        num = 9'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.word = 32'h89ABCDEF;
        bus.word_valid = 1'b1;
        @(negedge clk);
        chk("rml_rdy", 32'(bus.word_ready), 32'd1);
        sb.push_back({10'h040, 8'h89});
        sb.push_back({10'h041, 8'hAB});
        sb.push_back({10'h042, 8'hCD});
        tick();
        bus.word_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rml_wen", 32'(bus.w_en), 32'd0);
        chk("rml_busy", 32'(busy), 32'd0);
        chk("rml_rdy0", 32'(bus.word_ready), 32'd0);
        tick();
        tick();
        tick();
        chk("rml_sb", sb.size(), 0);
        chk("rml_done", n_done, 0);

        wq = '{32'h00000013};
        load(10'h080, 0, 1'b0);
        chk("mem_080", {mem[128], mem[129], mem[130], mem[131]}, 32'h00000013);

`ifdef ISRAM_LOADER_READBACK_EN
        stuck = 1'b1;
        wq = '{32'hDEADBEEF, 32'h01234567};
        load(10'h010, 0, 1'b0);
        chk("rb_err", 32'(err), 32'd1);
        stuck = 1'b0;
        wq = '{32'hDEADBEEF};
        load(10'h010, 0, 1'b0);
        chk("rb_ok", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
